// File: rtl/led_blink_tx_pkg.sv
// Shared types and default unit lengths for the LED blink transmitter.
package led_blink_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE,
    FRAME_GAP
  } state_e;

  localparam int SHORT_UNITS_D     = 1;
  localparam int LONG_UNITS_D      = 3;
  localparam int GAP_UNITS_D       = 1;
  localparam int FRAME_GAP_UNITS_D = 4;

  function automatic int max_units(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/led_blink_tx_if.sv
// Valid/ready payload channel feeding the LED blink transmitter.
interface led_blink_tx_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/led_unit_timer.sv
// Unit prescaler: ticks on the last cycle of every UNIT_CYCLES-cycle unit,
// restarting its count from zero whenever restart is high.
module led_unit_timer #(
  parameter int UNIT_CYCLES = 125_000
) (
  input  logic sysclk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(UNIT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // tick must not depend on restart: restart is derived from tick upstream
  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/led_blink_tx.sv
// Sends a DATA_W-bit word MSB-first as long/short LED marks separated by gaps.
// Optional even-parity trailer bit enabled by macro LED_BLINK_TX_PARITY_EN.
module led_blink_tx
  import led_blink_tx_pkg::*;
#(
  parameter int UNIT_CYCLES     = 125_000,
  parameter int DATA_W          = 4,
  parameter int SHORT_UNITS     = SHORT_UNITS_D,
  parameter int LONG_UNITS      = LONG_UNITS_D,
  parameter int GAP_UNITS       = GAP_UNITS_D,
  parameter int FRAME_GAP_UNITS = FRAME_GAP_UNITS_D
) (
  input  logic             sysclk,
  input  logic             reset,
  led_blink_tx_if.slave    in_if,
  output logic             led_out,
  output logic             busy,
  output logic             done
);

`ifdef LED_BLINK_TX_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int UMAX = max_units(SHORT_UNITS, LONG_UNITS, GAP_UNITS, FRAME_GAP_UNITS);
  localparam int UW   = $clog2(UMAX + 1);
  localparam int IW   = $clog2(DATA_W + 1);

  localparam logic [UW-1:0] SHORT_U = UW'(SHORT_UNITS);
  localparam logic [UW-1:0] LONG_U  = UW'(LONG_UNITS);
  localparam logic [UW-1:0] GAP_U   = UW'(GAP_UNITS);
  localparam logic [UW-1:0] FGAP_U  = UW'(FRAME_GAP_UNITS);

  state_e            state_q, state_d;
  logic [NBITS-1:0]  word_q, word_d, load_word;
  logic [IW-1:0]     idx_q, idx_d;
  logic [UW-1:0]     units_q, units_d;
  logic              led_q, led_d, done_q, done_d;
  logic              tick, restart, next_bit;

`ifdef LED_BLINK_TX_PARITY_EN
  assign load_word = {in_if.data, ^in_if.data};
`else
  assign load_word = in_if.data;
`endif

  function automatic logic [UW-1:0] mark_len(input logic b);
    return b ? LONG_U : SHORT_U;
  endfunction

  // Bit that the next mark will carry once the index steps down
  always_comb begin
    next_bit = 1'b0;
    for (int i = 0; i < NBITS; i++)
      if (int'(idx_q) == i + 1) next_bit = word_q[i];
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    units_d = units_q;
    case (state_q)
      IDLE: begin
        if (in_if.valid) begin
          state_d = MARK;
          word_d  = load_word;
          idx_d   = IW'(NBITS - 1);
          units_d = mark_len(load_word[NBITS-1]);
        end
      end
      MARK: begin
        if (tick) begin
          if (units_q == UW'(1)) begin
            state_d = SPACE;
            units_d = GAP_U;
          end else begin
            units_d = units_q - UW'(1);
          end
        end
      end
      SPACE: begin
        if (tick) begin
          if (units_q != UW'(1)) begin
            units_d = units_q - UW'(1);
          end else if (idx_q != '0) begin
            state_d = MARK;
            idx_d   = idx_q - IW'(1);
            units_d = mark_len(next_bit);
          end else begin
            state_d = FRAME_GAP;
            units_d = FGAP_U;
          end
        end
      end
      FRAME_GAP: begin
        if (tick) begin
          if (units_q == UW'(1)) state_d = IDLE;
          else                   units_d = units_q - UW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Restarting the prescaler on every transition keeps each phase whole-unit exact
  assign restart = (state_d != state_q);
  assign led_d   = (state_d == MARK);
  assign done_d  = (state_q == FRAME_GAP) && (state_d == IDLE);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      units_q <= '0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      units_q <= units_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  led_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
    .sysclk  (sysclk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  assign in_if.ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign led_out     = led_q;
  assign done        = done_q;

endmodule
